// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parametrised sequence detector family:
// width helper, saturating increment and overlap-mode constants.
package seq_detect_pkg;

  localparam int OVL_OFF = 0;
  localparam int OVL_ON  = 1;

  // Bits needed to hold a fill level of 0..pat_w.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bit-stream and match-result bundle for seq_detect_param.
// Optional SEQ_DETECT_MASK_EN adds the pat_mask don't-care vector.
interface seq_detect_param_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  import seq_detect_pkg::*;

  localparam int FW = fill_w(PAT_W);

  logic             clr;
  logic             in_valid;
  logic             inp;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] pat_mask;
`endif
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [FW-1:0]    fill;

  // Bit source / controller side.
  modport master (
    output clr, in_valid, inp,
`ifdef SEQ_DETECT_MASK_EN
    output pat_mask,
`endif
    input  match, match_cnt, fill
  );

  // Detector side.
  modport slave (
    input  clr, in_valid, inp,
`ifdef SEQ_DETECT_MASK_EN
    input  pat_mask,
`endif
    output match, match_cnt, fill
  );

endinterface

// File: rtl/seq_detect_cnt.sv
// Saturating event counter with synchronous clear; shared by FSM-library blocks.
module seq_detect_cnt
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detect_cnt: CNT_W must be 1..32");
  end

  // Count up on inc, stick at all-ones, clear wins over inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (Mealy compare, registered match).
// Fill level 0..PAT_W acts as the detector state; FULL is absorbing when
// OVERLAP=1, a hit drops back to EMPTY when OVERLAP=0.
// Optional feature: define SEQ_DETECT_MASK_EN to add a pat_mask don't-care input.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int              PAT_W   = 3,
  parameter longint unsigned PATTERN = 3'b101,
  parameter int              OVERLAP = OVL_ON,
  parameter int              CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int             FW   = fill_w(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W must be 2..16");
  end
  if ((PATTERN >> PAT_W) != 0) begin : g_bad_pattern
    $error("seq_detect_param: PATTERN does not fit in PAT_W bits");
  end

  localparam logic [PAT_W-1:0] PAT = PATTERN[PAT_W-1:0];

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] mask;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_n;
  logic             match_q;
  logic             hit;
  logic             accept;

`ifdef SEQ_DETECT_MASK_EN
  assign mask = bus.pat_mask;
`else
  assign mask = '0;
`endif

  // clr discards the bit offered in the same cycle.
  assign accept = bus.in_valid && !bus.clr;

  // Next history/fill and the masked compare against the target.
  always_comb begin
    hist_n = {history[PAT_W-2:0], bus.inp};
    fill_n = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    hit    = (fill_n == FULL) && (((hist_n ^ PAT) & ~mask) == '0);
  end

  // Shift register, fill state and registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (bus.clr) begin
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (bus.in_valid) begin
      history <= hist_n;
      match_q <= hit;
      fill_q  <= (hit && OVERLAP == OVL_OFF) ? '0 : fill_n;
    end else begin
      match_q <= 1'b0;
    end
  end

  seq_detect_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (accept && hit),
    .cnt (bus.match_cnt)
  );

  assign bus.match = match_q;
  assign bus.fill  = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three builds (overlap, non-overlap,
// 2-bit saturating counter) share one stimulus stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic vld = 1'b0;
  logic inp = 1'b0;
  logic [2:0] msk = 3'b000;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) if_ovl ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) if_nov ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(2)) if_sat ();

  assign if_ovl.clr = clr; assign if_ovl.in_valid = vld; assign if_ovl.inp = inp;
  assign if_nov.clr = clr; assign if_nov.in_valid = vld; assign if_nov.inp = inp;
  assign if_sat.clr = clr; assign if_sat.in_valid = vld; assign if_sat.inp = inp;
`ifdef SEQ_DETECT_MASK_EN
  assign if_ovl.pat_mask = msk;
  assign if_nov.pat_mask = msk;
  assign if_sat.pat_mask = msk;
`endif

  seq_detect_param #(.PAT_W(3), .PATTERN(5), .OVERLAP(1), .CNT_W(8)) u_ovl (
    .clk(clk), .rst(rst), .bus(if_ovl.slave));
  seq_detect_param #(.PAT_W(3), .PATTERN(5), .OVERLAP(0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .bus(if_nov.slave));
  seq_detect_param #(.PAT_W(3), .PATTERN(5), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat.slave));

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present one cycle of input, then sample just after the rising edge.
  task automatic step(input logic c, input logic v, input logic b);
    @(negedge clk);
    clr = c; vld = v; inp = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    // Reset state
    #12;
    chk("rst_fill", if_ovl.fill, 0);
    chk("rst_match", if_ovl.match, 0);
    chk("rst_cnt", if_ovl.match_cnt, 0);
    @(negedge clk); rst = 1'b1;

    // 1,0,1,0,1 continuous: overlap vs non-overlap
    step(0, 1, 1);
    chk("t1_b1_fill", if_ovl.fill, 1);
    chk("t1_b1_match", if_ovl.match, 0);
    step(0, 1, 0);
    chk("t1_b2_fill", if_ovl.fill, 2);
    step(0, 1, 1);
    chk("t1_b3_match", if_ovl.match, 1);
    chk("t1_b3_fill", if_ovl.fill, 3);
    chk("t2_b3_match", if_nov.match, 1);
    chk("t2_b3_fill", if_nov.fill, 0);
    step(0, 1, 0);
    chk("t1_b4_match", if_ovl.match, 0);
    chk("t2_b4_fill", if_nov.fill, 1);
    step(0, 1, 1);
    chk("t1_b5_match", if_ovl.match, 1);
    chk("t1_b5_cnt", if_ovl.match_cnt, 2);
    chk("t1_b5_fill", if_ovl.fill, 3);
    chk("t2_b5_match", if_nov.match, 0);
    chk("t2_b5_fill", if_nov.fill, 2);
    chk("t2_b5_cnt", if_nov.match_cnt, 1);

    // Clear with a valid bit present: bit discarded
    step(1, 1, 1);
    chk("clr_cnt", if_ovl.match_cnt, 0);
    chk("clr_fill", if_ovl.fill, 0);
    chk("clr_match", if_ovl.match, 0);

    // Gapped stream 1,gap,0,gap,1
    step(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      chk("t3_gap1_match", if_ovl.match, 0);
    end
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      chk("t3_gap2_match", if_ovl.match, 0);
    end
    chk("t3_hold_fill", if_ovl.fill, 2);
    step(0, 1, 1);
    chk("t3_match", if_ovl.match, 1);
    chk("t3_cnt", if_ovl.match_cnt, 1);
    chk("t3_nov_match", if_nov.match, 1);
    step(0, 0, 0);
    chk("t3_after_match", if_ovl.match, 0);

    // Saturating 2-bit counter over 5 hits
    step(1, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      step(0, 1, (i % 2) == 1);
      if (i >= 3 && (i % 2) == 1) begin
        chk("t4_match", if_sat.match, 1);
        chk("t4_cnt", if_sat.match_cnt, sat_exp[(i - 3) / 2]);
      end
    end
    step(1, 1, 1);
    chk("t4_clr_cnt", if_sat.match_cnt, 0);
    chk("t4_clr_fill", if_sat.fill, 0);
    chk("t4_clr_match", if_sat.match, 0);

    // Async reset mid-sequence
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    chk("t5_pre_cnt", if_ovl.match_cnt, 1);
    step(0, 1, 1); step(0, 1, 0);
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_cnt", if_ovl.match_cnt, 0);
    chk("t5_rst_fill", if_ovl.fill, 0);
    chk("t5_rst_match", if_ovl.match, 0);
    @(negedge clk); rst = 1'b1;
    step(0, 1, 1);
    chk("t5_no_match", if_ovl.match, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("t5_match", if_ovl.match, 1);

`ifdef SEQ_DETECT_MASK_EN
    // Middle bit don't-care
    step(1, 0, 0);
    msk = 3'b010;
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    chk("t6_mask_match", if_ovl.match, 1);
    step(1, 0, 0);
    msk = 3'b000;
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    chk("t6_nomask_match", if_ovl.match, 0);
`endif

    step(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It is the next generation of the fixed 2-bit-state Mealy sequence FSM in the FSM library.
- Matches an arbitrary PAT_W-bit pattern on a 1-bit serial input gated by a valid strobe.
- Supports overlapping and non-overlapping detection.
- Keeps a saturating match counter.
- Sits between a serial bit source and control logic that needs a registered match pulse.

Parameters:
- PAT_W, 3: pattern length in bits, legal range 2..16.
- PATTERN, 3'b101: target sequence. MSB is the oldest bit received, LSB is the newest.
- OVERLAP, 1: 1 means the tail of a match may start the next match; 0 means detection restarts from empty after each match.
- CNT_W, 8: width of the match counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- clr, input, 1: synchronous clear of fill, match and counter.
- in_valid, input, 1: inp is sampled this cycle when high.
- inp, input, 1: serial data bit.
- match, output, 1: one-cycle registered pulse when a pattern completes.
- match_cnt, output, CNT_W: number of matches since reset/clr; saturates.
- fill, output, $clog2(PAT_W+1): number of valid history bits, 0..PAT_W.

Behaviour:
- Reset (rst=0, asynchronous): history=0, fill=0, match=0, match_cnt=0. Outputs hold these values until the first rising edge with rst=1.
- clr=1 at an edge: fill=0, match=0, match_cnt=0; history is don't-care. clr overrides in_valid in the same cycle; that bit is discarded.
- in_valid=0, clr=0: history, fill and match_cnt hold; match is driven 0.
- in_valid=1, clr=0:
  - hist_n = {history[PAT_W-2:0], inp}.
  - fill_n = min(fill+1, PAT_W).
  - hit = (fill_n==PAT_W) && (hist_n==PATTERN).
  - history <= hist_n.
  - match <= hit, so match rises the cycle after the edge that accepted the completing bit. Latency is 1 clock.
  - match_cnt <= match_cnt+1 on hit, unless already all-ones; then it holds (no wrap).
  - fill <= (hit && !OVERLAP) ? 0 : fill_n.
- Each "cycle" below means an accepted bit (in_valid=1). With in_valid=1 every clock, one match pulse per detected occurrence; back-to-back pulses are legal in overlap mode when the pattern allows it (e.g. 111 on an all-ones stream).
- Detector states are fill values EMPTY(0) .. FULL(PAT_W). FULL is absorbing in overlap mode. In non-overlap mode a hit returns the state to EMPTY.
- Gaps in in_valid do not break a partial match; a sequence is defined over accepted bits only.
- rst asserted mid-sequence discards any partial match; no pulse is produced for it.
- Elaboration-time error if PAT_W<2 or PATTERN does not fit in PAT_W bits.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- When defined:
  - Adds input port pat_mask [PAT_W-1:0]. A 1 bit marks that position as don't-care.
  - Compare becomes ((hist_n ^ PATTERN) & ~pat_mask) == 0.
  - pat_mask is sampled combinationally each accepted cycle.
- When undefined:
  - Port absent; exact compare as above.
  - Behaviour identical to the masked build with pat_mask=0.

Decomposition:
- Package seq_detect_pkg holds:
  - width helper function fill_w(PAT_W) returning $clog2(PAT_W+1);
  - saturating-increment function sat_inc;
  - mode localparams OVL_ON=1 and OVL_OFF=0.
- One natural sub-module: seq_detect_cnt, the saturating CNT_W counter with clr and inc inputs, reused by other FSM-library blocks.
- Shift/compare logic stays in the top.

Test Plan:
1. Defaults, OVERLAP=1, in_valid=1 continuously, bits 1,0,1,0,1 -> match pulses after bit 3 and bit 5; match_cnt=2; fill stays 3.
2. Same stream with OVERLAP=0 -> single pulse after bit 3; fill goes 0 then 1,2; match_cnt=1.
3. Bits 1,(gap 4 cycles in_valid=0),0,(gap),1 -> exactly one pulse, one clock after the final accepted 1; no pulse during gaps.
4. CNT_W=2, overlap, stream 1,0,1,0,1,0,1,0,1,0,1 (5 hits) -> match_cnt 1,2,3,3,3; match still pulses each hit. Then clr=1 with in_valid=1, inp=1 -> cnt=0, fill=0, no pulse.
5. Async reset: drive 1,0, pull rst low between clock edges -> match_cnt, fill and match go 0 immediately. Release and drive 1 -> no match; then 0,1 -> match.
6. SEQ_DETECT_MASK_EN defined, pat_mask=3'b010, stream 1,1,1 -> match after bit 3 (middle bit ignored). Same stream with pat_mask=0 -> no match.
